// File: rtl/axi_lite_image_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_image_master
//  Purpose  : AXI4-Lite master that streams one image from a local pixel RAM
//             into the SNN coprocessor register file, triggers it, polls the
//             status register for the ready bit and then clears the trigger.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_image_master #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS      = 8,
  parameter int ADDR_STRIDE     = 1,
  parameter int POLL_GAP        = 16,
  parameter int POLL_MAX        = 65535
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       START,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERROR,
  output logic [7:0]                 DIGIT,
  output logic [IMAGE_SIZE_BITS-1:0] PIX_RADDR,
  input  logic [PIXEL_BITS-1:0]      PIX_RDATA,
  output logic [31:0]                AWADDR,
  output logic [2:0]                 AWPROT,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [31:0]                WDATA,
  output logic [3:0]                 WSTRB,
  output logic                       WVALID,
  input  logic                       WREADY,
  input  logic [1:0]                 BRESP,
  input  logic                       BVALID,
  output logic                       BREADY,
  output logic [31:0]                ARADDR,
  output logic [2:0]                 ARPROT,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [31:0]                RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RVALID,
  output logic                       RREADY
);

  localparam int POLL_BITS = $clog2(POLL_MAX + 1);
  localparam int GAP_BITS  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [POLL_BITS-1:0]       POLL_LIMIT = POLL_BITS'(POLL_MAX);
  localparam logic [GAP_BITS-1:0]        GAP_LAST   = GAP_BITS'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX   = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [31:0]                STRIDE     = 32'(ADDR_STRIDE);
  localparam logic [31:0]                TRIG_ADDR  = 32'(IMAGE_SIZE * ADDR_STRIDE);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR, S_WRESP, S_TRIG, S_TRESP,
    S_GAP, S_RADDR, S_RDATA_S, S_CLR, S_CRESP, S_FIN
  } state_t;

  state_t                     state, state_n;
  logic                       fetch_wait, fetch_wait_n;
  logic [POLL_BITS-1:0]       poll_cnt, poll_n;
  logic [GAP_BITS-1:0]        gap_cnt, gap_n;
  logic [IMAGE_SIZE_BITS-1:0] idx_n;
  logic                       busy_n, done_n, error_n;
  logic [7:0]                 digit_n;
  logic [31:0]                awaddr_n, wdata_n;
  logic [3:0]                 wstrb_n;
  logic                       awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic                       start_clr;

  // Only the ready flag and digit byte of the status word carry meaning.
  logic unused_rdata;
  assign unused_rdata = ^{RDATA[30:8], 1'b0};

  // Protection bits and the status register address never change.
  assign AWPROT = 3'b000;
  assign ARPROT = 3'b000;
  assign ARADDR = 32'd0;

  // Register every output and FSM variable; reset drops any open handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state      <= S_IDLE;
      fetch_wait <= 1'b0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      PIX_RADDR  <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      DIGIT      <= 8'd0;
      AWADDR     <= 32'd0;
      WDATA      <= 32'd0;
      WSTRB      <= 4'd0;
      AWVALID    <= 1'b0;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_wait <= fetch_wait_n;
      poll_cnt   <= poll_n;
      gap_cnt    <= gap_n;
      PIX_RADDR  <= idx_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
      ERROR      <= error_n;
      DIGIT      <= digit_n;
      AWADDR     <= awaddr_n;
      WDATA      <= wdata_n;
      WSTRB      <= wstrb_n;
      AWVALID    <= awvalid_n;
      WVALID     <= wvalid_n;
      BREADY     <= bready_n;
      ARVALID    <= arvalid_n;
      RREADY     <= rready_n;
    end
  end

  // Next-state and next-output decode; PIX_RADDR doubles as the pixel index.
  always_comb begin
    state_n      = state;
    fetch_wait_n = fetch_wait;
    poll_n       = poll_cnt;
    gap_n        = gap_cnt;
    idx_n        = PIX_RADDR;
    busy_n       = BUSY;
    done_n       = 1'b0;
    error_n      = ERROR;
    digit_n      = DIGIT;
    awaddr_n     = AWADDR;
    wdata_n      = WDATA;
    wstrb_n      = WSTRB;
    awvalid_n    = AWVALID;
    wvalid_n     = WVALID;
    bready_n     = BREADY;
    arvalid_n    = ARVALID;
    rready_n     = RREADY;
    start_clr    = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          busy_n       = 1'b1;
          error_n      = 1'b0;
          idx_n        = '0;
          fetch_wait_n = 1'b0;
          state_n      = S_FETCH;
        end
      end
      S_FETCH: begin
        // First cycle lets the RAM register the address, second captures data.
        if (!fetch_wait) begin
          fetch_wait_n = 1'b1;
        end else begin
          fetch_wait_n = 1'b0;
          awaddr_n     = 32'(PIX_RADDR) * STRIDE;
          wdata_n      = 32'(PIX_RDATA);
          wstrb_n      = 4'b0001;
          awvalid_n    = 1'b1;
          wvalid_n     = 1'b1;
          state_n      = S_WR;
        end
      end
      S_WR, S_TRIG, S_CLR: begin
        if (AWVALID && AWREADY) awvalid_n = 1'b0;
        if (WVALID && WREADY)   wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = (state == S_WR)   ? S_WRESP :
                     (state == S_TRIG) ? S_TRESP : S_CRESP;
        end
      end
      S_WRESP, S_TRESP, S_CRESP: begin
        if (BVALID && BREADY) begin
          bready_n = 1'b0;
          if (BRESP != 2'b00) begin
            error_n = 1'b1;
            state_n = S_FIN;
          end else if (state == S_WRESP) begin
            if (PIX_RADDR == LAST_IDX) begin
              awaddr_n  = TRIG_ADDR;
              wdata_n   = 32'd1;
              wstrb_n   = 4'b1111;
              awvalid_n = 1'b1;
              wvalid_n  = 1'b1;
              state_n   = S_TRIG;
            end else begin
              idx_n   = PIX_RADDR + 1'b1;
              state_n = S_FETCH;
            end
          end else if (state == S_TRESP) begin
            poll_n    = '0;
            arvalid_n = 1'b1;
            state_n   = S_RADDR;
          end else begin
            state_n = S_FIN;
          end
        end
      end
      S_RADDR: begin
        if (ARVALID && ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = S_RDATA_S;
        end
      end
      S_RDATA_S: begin
        if (RVALID && RREADY) begin
          rready_n = 1'b0;
          poll_n   = poll_cnt + 1'b1;
          if (RRESP != 2'b00) begin
            error_n   = 1'b1;
            start_clr = 1'b1;
          end else if (RDATA[31]) begin
            digit_n   = RDATA[7:0];
            start_clr = 1'b1;
          end else if (poll_n == POLL_LIMIT) begin
            error_n   = 1'b1;
            start_clr = 1'b1;
          end else begin
            gap_n   = '0;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          arvalid_n = 1'b1;
          state_n   = S_RADDR;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      S_FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // The trigger-clear write follows every poll outcome.
    if (start_clr) begin
      awaddr_n  = TRIG_ADDR;
      wdata_n   = 32'd0;
      wstrb_n   = 4'b1111;
      awvalid_n = 1'b1;
      wvalid_n  = 1'b1;
      state_n   = S_CLR;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_image_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_image_master
//  Purpose  : Directed self-checking bench for axi_lite_image_master with a
//             small reactive AXI4-Lite slave and pixel RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_image_master;

  localparam int N      = 16;
  localparam int STRIDE = 4;
  localparam int GAP    = 16;
  localparam int PMAX   = 4;
  localparam int NB     = $clog2(N);

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          START;
  logic          BUSY, DONE, ERROR;
  logic [7:0]    DIGIT;
  logic [NB-1:0] PIX_RADDR;
  logic [7:0]    PIX_RDATA;
  logic [31:0]   AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]    AWPROT, ARPROT;
  logic [3:0]    WSTRB;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]    BRESP, RRESP;

  axi_lite_image_master #(
    .IMAGE_SIZE(N), .PIXEL_BITS(8), .ADDR_STRIDE(STRIDE),
    .POLL_GAP(GAP), .POLL_MAX(PMAX)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .BUSY(BUSY), .DONE(DONE),
    .ERROR(ERROR), .DIGIT(DIGIT), .PIX_RADDR(PIX_RADDR), .PIX_RDATA(PIX_RDATA),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Pixel RAM with one cycle read latency.
  logic [7:0] ram [N];
  always @(posedge ACLK) PIX_RDATA <= ram[PIX_RADDR];

  // Slave configuration, set by the stimulus between runs.
  int         aw_delay = 0, w_delay = 0, err_at = -1, ready_at = 1;
  logic [7:0] digit_val = 8'd7;
  logic       clear_req = 1'b0;

  int aw_wait, w_wait;
  assign AWREADY = (aw_wait >= aw_delay);
  assign WREADY  = (w_wait >= w_delay);
  assign ARREADY = 1'b1;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_wait <= 0;
      w_wait  <= 0;
    end else begin
      if (AWVALID && AWREADY) aw_wait <= 0; else if (AWVALID) aw_wait <= aw_wait + 1;
      if (WVALID && WREADY)   w_wait  <= 0; else if (WVALID)  w_wait  <= w_wait + 1;
    end
  end

  // Slave response model plus protocol monitor.
  logic [31:0] aw_q[$], wd_q[$];
  logic [3:0]  ws_q[$];
  logic        aw_got, w_got, pend_aw, pend_w, hs_aw, hs_w;
  logic [31:0] pend_aw_addr, pend_w_data;
  logic [3:0]  pend_w_strb;
  int          b_cnt, rd_cnt, viol, cyc = 0, last_r, min_gap;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_got <= 1'b0; w_got <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
      RVALID <= 1'b0; RDATA <= 32'd0; RRESP <= 2'b00;
      pend_aw <= 1'b0; pend_w <= 1'b0; hs_aw <= 1'b0; hs_w <= 1'b0;
    end else if (clear_req) begin
      aw_q.delete(); wd_q.delete(); ws_q.delete();
      b_cnt <= 0; rd_cnt <= 0; viol <= 0; last_r <= -1; min_gap <= 1000000;
    end else begin
      if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_q.push_back(AWADDR); end
      if (WVALID && WREADY) begin w_got <= 1'b1; wd_q.push_back(WDATA); ws_q.push_back(WSTRB); end
      if (aw_got && w_got && !BVALID) begin
        BVALID <= 1'b1;
        BRESP  <= (b_cnt == err_at) ? 2'b10 : 2'b00;
      end
      if (BVALID && BREADY) begin
        BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= b_cnt + 1;
      end
      if (ARVALID && ARREADY) begin
        rd_cnt <= rd_cnt + 1;
        RVALID <= 1'b1;
        RRESP  <= 2'b00;
        RDATA  <= (rd_cnt + 1 >= ready_at) ? {1'b1, 23'd0, digit_val} : 32'h0000_00AA;
        if (last_r >= 0 && (cyc - last_r - 1) < min_gap) min_gap <= cyc - last_r - 1;
      end
      if (RVALID && RREADY) begin RVALID <= 1'b0; last_r <= cyc; end
      // VALID held with stable payload until accepted, dropped right after.
      if (pend_aw && (!AWVALID || AWADDR != pend_aw_addr)) viol <= viol + 1;
      if (pend_w && (!WVALID || WDATA != pend_w_data || WSTRB != pend_w_strb)) viol <= viol + 1;
      if ((hs_aw && AWVALID) || (hs_w && WVALID)) viol <= viol + 1;
      if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) viol <= viol + 1;
      pend_aw <= AWVALID && !AWREADY; pend_aw_addr <= AWADDR;
      pend_w  <= WVALID && !WREADY;   pend_w_data  <= WDATA; pend_w_strb <= WSTRB;
      hs_aw   <= AWVALID && AWREADY;
      hs_w    <= WVALID && WREADY;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    @(negedge ACLK) clear_req = 1'b1;
    @(negedge ACLK) clear_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    BUSY,      0);
    check({tag, "_done"},    DONE,      0);
    check({tag, "_error"},   ERROR,     0);
    check({tag, "_digit"},   DIGIT,     0);
    check({tag, "_valids"},  {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    check({tag, "_awaddr"},  AWADDR,    0);
    check({tag, "_wdata"},   WDATA,     0);
    check({tag, "_wstrb"},   WSTRB,     0);
    check({tag, "_araddr"},  ARADDR,    0);
    check({tag, "_praddr"},  PIX_RADDR, 0);
  endtask

  // Pulse START, wait for DONE with a cycle budget, verify the pulse shape.
  task automatic run_image(input string tag, input bit mid_start);
    int t = 0;
    clear_stats();
    START = 1'b1;
    @(negedge ACLK) START = 1'b0;
    check({tag, "_busy_on"}, BUSY, 1);
    check({tag, "_err_clr"}, ERROR, 0);
    while (!DONE && t < 20000) begin
      @(negedge ACLK);
      START = mid_start && (t == 20);
      t++;
    end
    START = 1'b0;
    check({tag, "_done"}, DONE, 1);
    check({tag, "_busy_off"}, BUSY, 0);
    @(negedge ACLK);
    check({tag, "_done_pulse"}, DONE, 0);
  endtask

  // Compare the captured write sequence with the expected image transfer.
  task automatic check_writes(input string tag, input int npix, input bit trig, input bit clr);
    int bad = 0;
    int exp_n = npix + int'(trig) + int'(clr);
    check({tag, "_wr_count"}, aw_q.size(), exp_n);
    check({tag, "_w_count"},  wd_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < aw_q.size() && i < wd_q.size(); i++) begin
      if (i < npix) begin
        if (aw_q[i] != i * STRIDE || wd_q[i] != {24'd0, ram[i]} || ws_q[i] != 4'b0001) bad++;
      end else if (trig && i == npix) begin
        if (aw_q[i] != N * STRIDE || wd_q[i] != 32'd1 || ws_q[i] != 4'b1111) bad++;
      end else begin
        if (aw_q[i] != N * STRIDE || wd_q[i] != 32'd0 || ws_q[i] != 4'b1111) bad++;
      end
    end
    check({tag, "_wr_seq"}, bad, 0);
    check({tag, "_protocol"}, viol, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < N; i++) ram[i] = 8'(i * 7 + 3);
    ARESETN = 1'b0;
    START   = 1'b0;
    repeat (3) @(negedge ACLK);
    check_reset_outputs("rst0");
    check("rst0_prot", {AWPROT, ARPROT}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Always-ready slave, ready on first poll, stray START mid-run ignored.
    run_image("basic", 1'b1);
    check_writes("basic", N, 1'b1, 1'b1);
    check("basic_reads", rd_cnt, 1);
    check("basic_digit", DIGIT, 7);
    check("basic_error", ERROR, 0);
    check("basic_idle", BUSY, 0);

    // Slow AWREADY, then slow WREADY.
    aw_delay = 3; w_delay = 0;
    run_image("awslow", 1'b0);
    check_writes("awslow", N, 1'b1, 1'b1);
    aw_delay = 0; w_delay = 3;
    run_image("wslow", 1'b0);
    check_writes("wslow", N, 1'b1, 1'b1);
    w_delay = 0;

    // Ready bit appears on the fourth (last permitted) poll.
    ready_at = 4; digit_val = 8'd4;
    run_image("poll", 1'b0);
    check_writes("poll", N, 1'b1, 1'b1);
    check("poll_reads", rd_cnt, 4);
    check("poll_gap", min_gap >= GAP, 1);
    check("poll_digit", DIGIT, 4);
    check("poll_error", ERROR, 0);

    // Error response on pixel 10 aborts before the trigger.
    err_at = 10; ready_at = 1; digit_val = 8'd9;
    run_image("bresp", 1'b0);
    check_writes("bresp", 11, 1'b0, 1'b0);
    check("bresp_reads", rd_cnt, 0);
    check("bresp_error", ERROR, 1);
    check("bresp_digit", DIGIT, 4);
    repeat (5) @(negedge ACLK);
    check("bresp_sticky", ERROR, 1);
    err_at = -1;

    // Ready never set: timeout after POLL_MAX reads, clear still written.
    ready_at = 1000;
    run_image("tmo", 1'b0);
    check_writes("tmo", N, 1'b1, 1'b1);
    check("tmo_reads", rd_cnt, PMAX);
    check("tmo_error", ERROR, 1);
    check("tmo_digit", DIGIT, 4);

    // Reset in the middle of pixel 12's write, then a clean run.
    ready_at = 1; digit_val = 8'd9; aw_delay = 3;
    clear_stats();
    START = 1'b1;
    @(negedge ACLK) START = 1'b0;
    t = 0;
    while (!(aw_q.size() == 12 && AWVALID) && t < 5000) begin
      @(negedge ACLK);
      t++;
    end
    check("midrst_reached", aw_q.size() == 12 && AWVALID, 1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check_reset_outputs("midrst");
    @(negedge ACLK) ARESETN = 1'b1;
    aw_delay = 0;
    run_image("rerun", 1'b0);
    check_writes("rerun", N, 1'b1, 1'b1);
    check("rerun_digit", DIGIT, 9);
    check("rerun_error", ERROR, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
